// File: rtl/seg_pkg.sv
// Shared constants, FSM encoding and helpers for the 7-segment scan controller.
// Build option: SEG_LZB_EN enables leading-zero blanking (used in seg_scan_ctrl).
package seg_pkg;

  localparam int          DIGITS    = 4;
  localparam int          BIN_WIDTH = 16;
  localparam int          BCD_WIDTH = 20;
  localparam int          IDX_W     = 2;
  localparam logic [3:0]  BCD_BLANK = 4'hF;
  localparam logic [15:0] MAX_DISP  = 16'd9999;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } seg_state_t;

  // Double-dabble correction: a BCD nibble of 5 or more gets +3 before the shift.
  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/seg_bin2bcd.sv
// Iterative 16-bit binary to 5-digit BCD converter (shift-add-3, one bit per clock).
// start loads the operand; sixteen following edges shift; done is high during the
// cycle whose closing edge performs the final shift, so bcd is complete after it.
module seg_bin2bcd
  import seg_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BIN_WIDTH-1:0] bin_in,
  output logic [BCD_WIDTH-1:0] bcd,
  output logic                 done
);

  logic [BIN_WIDTH-1:0] bin_reg;
  logic [BCD_WIDTH-1:0] bcd_reg;
  logic [3:0]           cnt_reg;
  logic                 active_reg;
  logic [BCD_WIDTH-1:0] bcd_adj;

  genvar gi;
  generate
    for (gi = 0; gi < BCD_WIDTH / 4; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = add3(bcd_reg[4*gi +: 4]);
    end
  endgenerate

  // Operand load on start, otherwise one adjust-and-shift step per clock while active.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bin_reg    <= '0;
      bcd_reg    <= '0;
      cnt_reg    <= '0;
      active_reg <= 1'b0;
    end else if (start) begin
      bin_reg    <= bin_in;
      bcd_reg    <= '0;
      cnt_reg    <= '0;
      active_reg <= 1'b1;
    end else if (active_reg) begin
      {bcd_reg, bin_reg} <= {bcd_adj[BCD_WIDTH-2:0], bin_reg, 1'b0};
      cnt_reg            <= cnt_reg + 4'd1;
      if (cnt_reg == 4'd15) begin
        active_reg <= 1'b0;
      end
    end
  end

  assign done = active_reg && (cnt_reg == 4'd15);
  assign bcd  = bcd_reg;

endmodule

// File: rtl/seg_scan_ctrl.sv
// 4-digit 7-segment sequencer: latches a binary value on load, converts it to BCD
// through seg_bin2bcd, commits the digits to display registers and scans them out.
// Build option: SEG_LZB_EN blanks zero digits above the most significant nonzero one.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 32768,
  parameter int BIN_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] value,
  input  logic             load,
  output logic             busy,
  output logic             overflow,
  output logic [3:0]       digit_code,
  output logic [3:0]       sel
);

  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  seg_state_t state_reg, state_next;

  logic                 pend_reg;
  logic [BIN_W-1:0]     pend_val_reg;
  logic                 eng_start;
  logic [BIN_W-1:0]     eng_in;
  logic [BCD_WIDTH-1:0] eng_bcd;
  logic                 eng_done;
  logic                 ovf_next;
  logic                 ovf_reg;
  logic [4*DIGITS-1:0]  disp_all;
  logic [PRE_W-1:0]     pre_reg;
  logic [IDX_W-1:0]     idx_reg;
  logic [IDX_W-1:0]     idx_next;
  logic                 tick;
  logic [3:0]           sel_reg;
  logic [3:0]           dc_reg;

  seg_bin2bcd u_bin2bcd (
    .clk    (clk),
    .rst    (rst),
    .start  (eng_start),
    .bin_in (eng_in),
    .bcd    (eng_bcd),
    .done   (eng_done)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state: a waiting request (new load or pending) chains straight into CONV.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (load || pend_reg) state_next = CONV;
      CONV:    if (eng_done)         state_next = COMMIT;
      COMMIT:  state_next = (load || pend_reg) ? CONV : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: a fresh load outranks an older pending value (last request wins).
  always_comb begin
    busy      = (state_reg != IDLE);
    eng_start = (state_reg != CONV) && (load || pend_reg);
    eng_in    = load ? value : pend_val_reg;
  end

  // Pending slot catches loads arriving while a conversion is in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_reg     <= 1'b0;
      pend_val_reg <= '0;
    end else if (eng_start) begin
      pend_reg     <= 1'b0;
    end else if (load) begin
      pend_reg     <= 1'b1;
      pend_val_reg <= value;
    end
  end

  assign ovf_next = (eng_bcd[BCD_WIDTH-1:4*DIGITS] != 4'd0);

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_dig
      logic       blank_lz;
      logic [3:0] commit_dig;
      logic [3:0] disp_reg;
`ifdef SEG_LZB_EN
      if (gi == 0) begin : g_units
        assign blank_lz = 1'b0;
      end else begin : g_upper
        assign blank_lz = (eng_bcd[4*DIGITS-1:4*gi] == '0);
      end
`else
      assign blank_lz = 1'b0;
`endif
      assign commit_dig = (ovf_next || blank_lz) ? BCD_BLANK : eng_bcd[4*gi +: 4];

      // Display digit is rewritten only on the COMMIT edge.
      always_ff @(posedge clk) begin
        if (!rst) begin
          disp_reg <= BCD_BLANK;
        end else if (state_reg == COMMIT) begin
          disp_reg <= commit_dig;
        end
      end

      assign disp_all[4*gi +: 4] = disp_reg;
    end
  endgenerate

  // Overflow flag follows the most recently committed value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_reg <= 1'b0;
    end else if (state_reg == COMMIT) begin
      ovf_reg <= ovf_next;
    end
  end

  assign tick     = (pre_reg == PRE_W'(SCAN_DIV - 1));
  assign idx_next = tick ? idx_reg + IDX_W'(1) : idx_reg;

  // Free-running scan: select and digit code register together from the next index.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_reg <= '0;
      idx_reg <= '0;
      sel_reg <= 4'b1110;
      dc_reg  <= BCD_BLANK;
    end else begin
      pre_reg <= tick ? '0 : pre_reg + PRE_W'(1);
      idx_reg <= idx_next;
      sel_reg <= ~(4'b0001 << idx_next);
      dc_reg  <= disp_all[4*idx_next +: 4];
    end
  end

  assign overflow   = ovf_reg;
  assign sel        = sel_reg;
  assign digit_code = dc_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with a cycle model and a scoreboard of expected
// display contents (pushed on load, popped on the commit edge).
module tb_seg_scan_ctrl;

  localparam int SD  = 4;
  localparam int SD3 = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = 16'd0;
  logic        busy, overflow;
  logic [3:0]  digit_code, sel;

  logic        load3 = 1'b0;
  logic [15:0] value3 = 16'd0;
  logic        busy3, overflow3;
  logic [3:0]  digit_code3, sel3;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.SCAN_DIV(SD), .BIN_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .load       (load),
    .busy       (busy),
    .overflow   (overflow),
    .digit_code (digit_code),
    .sel        (sel)
  );

  seg_scan_ctrl #(.SCAN_DIV(SD3), .BIN_W(16)) dut3 (
    .clk        (clk),
    .rst        (rst),
    .value      (value3),
    .load       (load3),
    .busy       (busy3),
    .overflow   (overflow3),
    .digit_code (digit_code3),
    .sel        (sel3)
  );

  typedef struct packed {
    logic        ovf;
    logic [15:0] digs;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   errors  = 0;

  // model state
  logic [15:0] m_disp = 16'hFFFF;
  logic        m_ovf  = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_pend = 1'b0;
  logic [3:0]  m_dc   = 4'hF;
  int          m_cnt  = 0;
  int          m_pc   = 0;
  int          m_idx  = 0;
  int          m3_pc  = 0;
  int          m3_idx = 0;

  function automatic exp_t expect_of(input int v);
    exp_t e;
    int   p;
    e.ovf  = 1'b0;
    e.digs = 16'hFFFF;
    if (v > 9999) begin
      e.ovf = 1'b1;
    end else begin
      p = 1;
      for (int k = 0; k < 4; k++) begin
        e.digs[4*k +: 4] = 4'((v / p) % 10);
`ifdef SEG_LZB_EN
        if (k > 0 && v < p) e.digs[4*k +: 4] = 4'hF;
`endif
        p = p * 10;
      end
    end
    return e;
  endfunction

  task automatic cmp(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // one clock edge, with the model advanced by what the DUT sampled at it
  task automatic step();
    exp_t e;
    logic commit;
    @(posedge clk);
    if (!rst) begin
      m_pc = 0; m_idx = 0; m3_pc = 0; m3_idx = 0;
      m_disp = 16'hFFFF; m_ovf = 1'b0; m_busy = 1'b0; m_pend = 1'b0;
      m_cnt = 0; m_dc = 4'hF;
      q.delete();
    end else begin
      if (m_pc == SD - 1) begin m_pc = 0; m_idx = (m_idx + 1) % 4; end
      else m_pc++;
      if (m3_pc == SD3 - 1) begin m3_pc = 0; m3_idx = (m3_idx + 1) % 4; end
      else m3_pc++;
      m_dc   = m_disp[4*m_idx +: 4];
      commit = 1'b0;
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) commit = 1'b1;
      end
      if (commit) begin
        if (q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL scoreboard_empty observed=0 expected>0");
        end else begin
          e = q.pop_front();
          m_disp = e.digs;
          m_ovf  = e.ovf;
          $display("commit digits=%h overflow=%b", e.digs, e.ovf);
        end
        if (load) begin
          if (m_pend && q.size() > 0) q[0] = expect_of(int'(value));
          else q.push_back(expect_of(int'(value)));
          m_cnt = 17;
        end else if (m_pend) begin
          m_cnt = 17;
        end else begin
          m_busy = 1'b0;
        end
        m_pend = 1'b0;
      end else if (load) begin
        if (!m_busy) begin
          m_busy = 1'b1;
          m_cnt  = 17;
          q.push_back(expect_of(int'(value)));
        end else if (m_pend && q.size() > 0) begin
          q[q.size()-1] = expect_of(int'(value));
        end else begin
          q.push_back(expect_of(int'(value)));
          m_pend = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic check(input string tag);
    logic [3:0] one;
    one = 4'b0001;
    cmp({tag, ".busy"},  {15'd0, busy},        {15'd0, m_busy});
    cmp({tag, ".ovf"},   {15'd0, overflow},    {15'd0, m_ovf});
    cmp({tag, ".sel"},   {12'd0, sel},         {12'd0, ~(one << m_idx)});
    cmp({tag, ".code"},  {12'd0, digit_code},  {12'd0, m_dc});
    cmp({tag, ".sel3"},  {12'd0, sel3},        {12'd0, ~(one << m3_idx)});
    cmp({tag, ".code3"}, {12'd0, digit_code3}, 16'h000F);
    cmp({tag, ".busy3"}, {15'd0, busy3},       16'h0000);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step();
      check(tag);
    end
  endtask

  task automatic do_load(input int v, input string tag);
    value = 16'(v);
    load  = 1'b1;
    $display("load value=%0d busy=%b", v, busy);
    step();
    check(tag);
    load  = 1'b0;
  endtask

  initial begin
    // reset and idle scan
    rst = 1'b0;
    run(2, "reset");
    rst = 1'b1;
    run(20, "idle_scan");

    // basic value
    do_load(1234, "v1234");
    run(40, "v1234");

    // overflow and largest displayable value
    do_load(10000, "v10000");
    run(30, "v10000");
    do_load(65535, "v65535");
    run(30, "v65535");
    do_load(9999, "v9999");
    run(30, "v9999");

    // small values (leading zeros)
    do_load(7, "v7");
    run(30, "v7");
    do_load(0, "v0");
    run(30, "v0");

    // loads during a conversion: last one wins, 42 never shown
    do_load(5, "pend");
    run(2, "pend");
    do_load(42, "pend42");
    run(6, "pend");
    do_load(99, "pend99");
    run(45, "pend");

    // load in the commit cycle chains a new conversion
    do_load(321, "chain");
    run(16, "chain");
    do_load(4321, "chain2");
    run(40, "chain");

    // reset mid-conversion
    do_load(1234, "abort");
    run(7, "abort");
    rst = 1'b0;
    run(2, "abort_rst");
    rst = 1'b1;
    run(30, "after_abort");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
